mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one combinational 4x4 unsigned array multiplier between NREQ requesters.
- Requesters use valid/ready handshakes. The block arbitrates among them round-robin and registers the winning operands.
- It then registers the 8-bit product and returns it with the winner's ID on a response handshake.
- Sits between multiple small-datapath clients and the single multiplier instance.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NREQ), requester ID width. This is a localparam and is not overridable.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit is high in any cycle.
- req_a  input  NREQ*4  flattened multiplicands; requester k uses bits [4k+3:4k].
- req_b  input  NREQ*4  flattened multipliers; same slicing as req_a.
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  downstream accepts the product.
- rsp_id  output  IDW  requester index that owns rsp_p.
- rsp_p  output  8  unsigned product A*B.
- busy  output  1  high whenever the state is not IDLE.
- done_cnt  output  CNTW  count of completed response handshakes; wraps modulo 2^CNTW.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, done_cnt=0.
  - Round-robin pointer ptr=0, so requester 0 has top priority after reset.
  - Operand registers are cleared to 0.
- Reset mid-operation discards any accepted or in-flight operation. No response is produced for it and done_cnt is not incremented.
- req_ready is combinational from state, ptr and req_valid:
  - It is nonzero only in IDLE.
  - It is one-hot on the winner: the first requester with req_valid=1, searching ptr, ptr+1, ... modulo NREQ.
  - It is all-zero whenever no request is pending or the state is not IDLE.
- IDLE:
  - If any req_valid is set, the winner w is accepted this cycle.
  - Register opA=req_a[w], opB=req_b[w], idR=w; set ptr=(w+1) mod NREQ; go to CALC.
  - Otherwise stay in IDLE; ptr is unchanged.
- CALC (one cycle):
  - rsp_p <= opA*opB from the multiplier sub-path; rsp_id <= idR; rsp_valid <= 1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_p stable while rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, done_cnt <= done_cnt+1 (wrap), go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Latency and throughput:
  - Request accepted at edge t; rsp_valid is high from cycle t+2.
  - With rsp_ready held at 1, the block sustains one operation per 3 cycles.
- Arithmetic: unsigned 4x4 -> 8 bits with no truncation; 15*15=225.
- Requester-side rules:
  - A requester whose req_valid drops before it is granted is simply skipped.
  - Operands are sampled only in the grant cycle.
  - The block does not require requester data to stay stable beyond the grant cycle.
- Simultaneous requests: fairness is guaranteed. Any continuously valid requester is granted within NREQ grants.
- rsp_ready is ignored outside RESP.
- Illegal state encodings return to IDLE on the next edge.

Decomposition:
- Shared package mult_share_pkg holds:
  - the state enum typedef {IDLE, CALC, RESP};
  - the operand width constant OPW=4 and product width PW=8.
- One natural sub-module, rr_arbiter (parameter NREQ). Inputs: req vector, ptr, enable. Output: one-hot grant plus encoded index.
- The multiplier is instantiated, not reimplemented.

Test Plan:
- Reset then single request: req_valid=0001, a0=3, b0=5 -> req_ready=0001 in the same cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_p=15; rsp_ready=1 -> done_cnt=1.
- Corner values: a=15,b=15 -> rsp_p=225; a=0,b=9 -> rsp_p=0; a=8,b=2 -> rsp_p=16.
- Round-robin: all four valid continuously with rsp_ready=1, operands ak=k+1, bk=2 -> grant order 0,1,2,3,0; rsp_p sequence 2,4,6,8,2; rsp_id matches the grant order.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_p stay constant; req_ready stays all-zero; busy=1; no second accept.
- Reset mid-op: accept a1=7, b1=7, then assert rst_n=0 during CALC -> rsp_valid=0, done_cnt=0, ptr=0; the next request from requester 0 wins over requester 1.
- Counter wrap: with CNTW=4, run 17 operations -> done_cnt reads 1.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   OPW     : operand width of the shared multiplier
//   PW      : product width (OPW*2, no truncation)
//   state_t : arbiter FSM states
package mult_share_pkg;

    localparam int OPW = 4;
    localparam int PW  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/array_mult.sv
// Combinational unsigned array multiplier (OPW x OPW -> PW).
//   a, b : unsigned operands
//   p    : full-width product
module array_mult
    import mult_share_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  p
);

    // One shifted partial-product row per multiplier bit, summed down the array.
    always_comb begin
        p = '0;
        for (int i = 0; i < OPW; i++) begin
            if (b[i]) begin
                p = p + (PW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant selection.
//   req : request vector
//   ptr : highest-priority index; search runs ptr, ptr+1, ... modulo NREQ
//   en  : grants are produced only while enabled
//   gnt : one-hot grant (all zero when disabled or nothing requested)
//   idx : encoded index of the granted requester
//   any : a grant was issued
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int k;
        logic [IDW-1:0] kk;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        kk  = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            kk = IDW'(k);
            if (en && !any && req[kk]) begin
                any     = 1'b1;
                gnt[kk] = 1'b1;
                idx     = kk;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one 4x4 array multiplier among NREQ requesters.
// A round-robin winner is accepted in IDLE, its product is registered in
// CALC, and the product is offered on the response handshake in RESP.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b        : flattened operands, requester k at [4k+3:4k]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_p       : owner of the product and the product itself
//   busy                : FSM is not in IDLE
//   done_cnt            : completed responses, wraps modulo 2^CNTW
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and a response holds its payload
// stable until the transfer.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int CNTW = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*4-1:0] req_a,
    input  logic [NREQ*4-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_p,
    output logic              busy,
    output logic [CNTW-1:0]   done_cnt
);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [OPW-1:0]  op_a;
    logic [OPW-1:0]  op_b;
    logic [IDW-1:0]  id_r;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic [OPW-1:0]  sel_a;
    logic [OPW-1:0]  sel_b;
    logic [PW-1:0]   prod;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .en  (state == IDLE),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    array_mult u_mult (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    assign req_ready = gnt;
    assign busy      = (state != IDLE);

    // Grant is one-hot, so OR-ing the masked slices selects the winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                sel_a = sel_a | req_a[k*OPW +: OPW];
                sel_b = sel_b | req_b[k*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_any) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            id_r      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            done_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        op_a <= sel_a;
                        op_b <= sel_b;
                        id_r <= win_idx;
                        ptr  <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                    end
                end
                CALC: begin
                    rsp_p     <= prod;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNTW'(1);
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_ready;

  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_p;
  logic        busy;
  logic [15:0] done_cnt;

  logic [3:0]  w_req_ready;
  logic        w_rsp_valid;
  logic [1:0]  w_rsp_id;
  logic [7:0]  w_rsp_p;
  logic        w_busy;
  logic [3:0]  w_done_cnt;

  int tests;
  int fails;

  logic [11:0] exp_q[$];
  int          m_st;
  int          m_ptr;

  mult_share_arbiter #(.NREQ(4), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy), .done_cnt(done_cnt)
  );

  mult_share_arbiter #(.NREQ(4), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w_req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(w_rsp_id), .rsp_p(w_rsp_p), .busy(w_busy), .done_cnt(w_done_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rr_model(input logic [3:0] v, input int p);
    logic [3:0] g;
    g = '0;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (p + i) % 4;
      if (g == 4'd0 && v[k]) g[k] = 1'b1;
    end
    return g;
  endfunction

  // scoreboard: reference model evaluated between edges with inputs settled
  initial begin
    m_st  = 0;
    m_ptr = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        m_st  = 0;
        m_ptr = 0;
        exp_q.delete();
      end else begin
        case (m_st)
          0: begin
            logic [3:0] eg;
            int win;
            int a;
            int b;
            eg = rr_model(req_valid, m_ptr);
            tests++;
            if (req_ready !== eg) begin
              fails++;
              $display("FAIL sb_grant: req_ready=%b expected=%b", req_ready, eg);
            end
            tests++;
            if (busy !== 1'b0) begin
              fails++;
              $display("FAIL sb_busy_idle: busy=%b expected=0", busy);
            end
            if (eg != 4'd0) begin
              win = 0;
              for (int i = 0; i < 4; i++) if (eg[i]) win = i;
              a = int'((req_a >> (win * 4)) & 16'hF);
              b = int'((req_b >> (win * 4)) & 16'hF);
              exp_q.push_back({4'(win), 8'(a * b)});
              m_ptr = (win + 1) % 4;
              m_st  = 1;
            end
          end
          1: begin
            tests++;
            if (req_ready !== 4'd0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
              fails++;
              $display("FAIL sb_calc: req_ready=%b busy=%b rsp_valid=%b expected 0000/1/0",
                       req_ready, busy, rsp_valid);
            end
            m_st = 2;
          end
          default: begin
            tests++;
            if (req_ready !== 4'd0 || busy !== 1'b1 || rsp_valid !== 1'b1) begin
              fails++;
              $display("FAIL sb_resp: req_ready=%b busy=%b rsp_valid=%b expected 0000/1/1",
                       req_ready, busy, rsp_valid);
            end
            if (rsp_ready) begin
              logic [11:0] e;
              tests++;
              if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: response id=%0d p=%0d with nothing expected", rsp_id, rsp_p);
              end else begin
                e = exp_q.pop_front();
                if ({2'b00, rsp_id, rsp_p} !== e) begin
                  fails++;
                  $display("FAIL sb_rsp: id=%0d p=%0d expected id=%0d p=%0d",
                           rsp_id, rsp_p, e[11:8], e[7:0]);
                end
              end
              m_st = 0;
            end
          end
        endcase
      end
    end
  end

  // driver tasks
  task automatic set_op(input int k, input int a, input int b);
    req_a = (req_a & ~(16'hF << (k * 4))) | (16'(a & 15) << (k * 4));
    req_b = (req_b & ~(16'hF << (k * 4))) | (16'(b & 15) << (k * 4));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input int k, input int a, input int b);
    int n;
    @(negedge clk);
    set_op(k, a, b);
    req_valid = req_valid | (4'd1 << k);
    n = 0;
    #1;
    while (req_ready == 4'd0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (req_ready !== (4'd1 << k)) begin
      fails++;
      $display("FAIL op_grant: req_ready=%b expected=%b", req_ready, 4'd1 << k);
    end
    @(negedge clk);
    req_valid = req_valid & ~(4'd1 << k);
    n = 0;
    #1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (rsp_valid !== 1'b1 || rsp_p !== 8'(a * b) || rsp_id !== 2'(k)) begin
      fails++;
      $display("FAIL op_rsp: valid=%b id=%0d p=%0d expected valid=1 id=%0d p=%0d",
               rsp_valid, rsp_id, rsp_p, k, a * b);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    req_a = '0;
    req_b = '0;
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_p !== 8'd0 || busy !== 1'b0 ||
        done_cnt !== 16'd0 || req_ready !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: valid=%b id=%0d p=%0d busy=%b cnt=%0d ready=%b expected all 0",
               rsp_valid, rsp_id, rsp_p, busy, done_cnt, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_op(0, 3, 5);
    req_valid = 4'b0001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL single_ready: req_ready=%b expected=0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_calc: busy=%b rsp_valid=%b expected 1/0", busy, rsp_valid);
    end
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 8'd15) begin
      fails++;
      $display("FAIL single_rsp: valid=%b id=%0d p=%0d expected 1/0/15", rsp_valid, rsp_id, rsp_p);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || done_cnt !== 16'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_done: valid=%b cnt=%0d busy=%b expected 0/1/0", rsp_valid, done_cnt, busy);
    end
  endtask

  task automatic test_corner();
    int ca[4] = '{15, 0, 8, 1};
    int cb[4] = '{15, 9, 2, 15};
    for (int i = 0; i < 4; i++) run_op(i, ca[i], cb[i]);
    for (int i = 0; i < 4; i++) run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                                       int'($urandom_range(0, 15)));
  endtask

  task automatic test_round_robin();
    int n;
    int e;
    do_reset();
    for (int k = 0; k < 4; k++) set_op(k, k + 1, 2);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      e = g % 4;
      n = 0;
      #1;
      while (req_ready == 4'd0 && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      tests++;
      if (req_ready !== (4'd1 << e)) begin
        fails++;
        $display("FAIL rr_grant%0d: req_ready=%b expected=%b", g, req_ready, 4'd1 << e);
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || rsp_p !== 8'(2 * (e + 1))) begin
        fails++;
        $display("FAIL rr_rsp%0d: valid=%b id=%0d p=%0d expected 1/%0d/%0d",
                 g, rsp_valid, rsp_id, rsp_p, e, 2 * (e + 1));
      end
      if (g == 4) req_valid = 4'b0000;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_op(1, 7, 7);
    req_valid = 4'b0010;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL midop_accept: req_ready=%b expected=0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || done_cnt !== 16'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midop_reset: valid=%b cnt=%0d busy=%b expected 0/0/0", rsp_valid, done_cnt, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_op(0, 1, 1);
    set_op(1, 2, 2);
    req_valid = 4'b0011;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL midop_ptr: req_ready=%b expected=0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 8'd1) begin
      fails++;
      $display("FAIL midop_rsp: valid=%b id=%0d p=%0d expected 1/0/1", rsp_valid, rsp_id, rsp_p);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    tests++;
    if (done_cnt !== 16'd1) begin
      fails++;
      $display("FAIL midop_cnt: done_cnt=%0d expected=1", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    set_op(2, 9, 13);
    set_op(1, 2, 2);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    n = 0;
    #1;
    while (req_ready == 4'd0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL bp_grant: req_ready=%b expected=0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_p !== 8'd117 || req_ready !== 4'd0 ||
          busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d p=%0d ready=%b busy=%b expected 1/2/117/0000/1",
                 c, rsp_valid, rsp_id, rsp_p, req_ready, busy);
      end
      if (c < 5) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0010 || done_cnt !== 16'd2) begin
      fails++;
      $display("FAIL bp_release: req_ready=%b cnt=%0d expected 0010/2", req_ready, done_cnt);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 8'd4) begin
      fails++;
      $display("FAIL bp_second: valid=%b id=%0d p=%0d expected 1/1/4", rsp_valid, rsp_id, rsp_p);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_op(3, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    @(negedge clk);
    #1;
    tests++;
    if (w_done_cnt !== 4'd1) begin
      fails++;
      $display("FAIL wrap_cnt4: done_cnt=%0d expected=1", w_done_cnt);
    end
    tests++;
    if (done_cnt !== 16'd17) begin
      fails++;
      $display("FAIL wrap_cnt16: done_cnt=%0d expected=17", done_cnt);
    end
  endtask

  // main sequence and report
  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_corner();
    test_round_robin();
    test_reset_midop();
    test_backpressure();
    test_counter_wrap();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d expected responses never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
